// File: rtl/mod_inverse_unit.sv
// Modular inverse over the Kyber prime using Fermat's little theorem: a^(q-2) mod q,
// computed by left-to-right square-and-multiply with one Barrett-reduced product per cycle.
module mod_inverse_unit #(
   parameter int DATA_WIDTH = 12,
   parameter int MODULUS    = 3329
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] a,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  valid_out,
   output logic                  zero_err
);

   localparam int W  = DATA_WIDTH;
   localparam int PW = 2 * W;
   localparam int RW = W + 2;
   localparam int BW = 3 * W + 2;
   localparam int IW = $clog2(W);

   localparam logic [W-1:0]  EXP       = W'(MODULUS - 2);
   localparam logic [W-1:0]  Q_W       = W'(MODULUS);
   localparam logic [RW-1:0] Q_R       = RW'(MODULUS);
   localparam logic [BW-1:0] BARRETT_M = BW'((64'd1 << PW) / 64'(MODULUS));

   typedef enum logic [1:0] {
      IDLE,
      SQR,
      MUL
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   base_q, base_d;
   logic [W-1:0]   result_q, result_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           zeroFlag_q, zeroFlag_d;
   logic           validOut_q;
   logic           zeroErr_q;

   logic           accept;
   logic           done;
   logic [W-1:0]   aRed;
   logic [W-1:0]   mulOp;
   logic [PW-1:0]  product;
   logic [RW-1:0]  qHat;
   logic [RW-1:0]  rem0;
   logic [RW-1:0]  rem1;
   logic [W-1:0]   modRes;
   logic [W-1:0]   mulAcc;

   // Shared multiplier: squares acc in SQR, multiplies by base in MUL.
   // Barrett leaves at most two extra q in the remainder, removed by two conditional subtracts.
   always_comb begin
      mulOp   = (state_q == SQR) ? acc_q : base_q;
      product = {{W{1'b0}}, acc_q} * {{W{1'b0}}, mulOp};
      qHat    = RW'(({{(BW - PW){1'b0}}, product} * BARRETT_M) >> PW);
      rem0    = RW'(product) - qHat * Q_R;
      rem1    = (rem0 >= Q_R) ? rem0 - Q_R : rem0;
      modRes  = (rem1 >= Q_R) ? W'(rem1 - Q_R) : W'(rem1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            IDLE:    state_d = valid_in ? SQR : IDLE;
            SQR:     state_d = MUL;
            MUL:     state_d = (idx_q == '0) ? IDLE : SQR;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      ready  = (state_q == IDLE) && enable;
      accept = ready && valid_in;
      done   = enable && (state_q == MUL) && (idx_q == '0);
   end

   // Datapath next-state; every update is gated by enable so a stall freezes everything.
   always_comb begin
      aRed       = (a >= Q_W) ? a - Q_W : a;
      mulAcc     = EXP[idx_q] ? modRes : acc_q;
      acc_d      = acc_q;
      base_d     = base_q;
      idx_d      = idx_q;
      zeroFlag_d = zeroFlag_q;
      result_d   = result_q;
      if (accept) begin
         base_d     = aRed;
         acc_d      = W'(1);
         idx_d      = IW'(W - 1);
         zeroFlag_d = (aRed == '0);
      end else if (enable && (state_q == SQR)) begin
         acc_d = modRes;
      end else if (enable && (state_q == MUL)) begin
         acc_d = mulAcc;
         if (idx_q != '0) begin
            idx_d = idx_q - IW'(1);
         end
      end
      if (done) begin
         result_d = mulAcc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= W'(1);
         base_q     <= '0;
         idx_q      <= IW'(W - 1);
         zeroFlag_q <= 1'b0;
         result_q   <= '0;
         validOut_q <= 1'b0;
         zeroErr_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         zeroFlag_q <= zeroFlag_d;
         result_q   <= result_d;
         validOut_q <= done;
         zeroErr_q  <= done && zeroFlag_q;
      end
   end

   assign result    = result_q;
   assign valid_out = validOut_q;
   assign zero_err  = zeroErr_q;

endmodule

// File: doc/mod_inverse_unit.md
MOD_INVERSE_UNIT -- requirements
Module: mod_inverse_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, operand/result width.
REQ-002 SHALL have parameter MODULUS, default 3329, prime Kyber modulus q; exponent E = MODULUS-2 (3327 = 12'b1100_1111_1111) derived internally.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  global advance enable; low = stall.
REQ-006 SHALL have port valid_in  input  1  operand strobe.
REQ-007 SHALL have port a  input  DATA_WIDTH  operand, any value 0..4095.
REQ-008 SHALL have port ready  output  1  unit can accept an operand this cycle.
REQ-009 SHALL have port result  output  DATA_WIDTH  a^-1 mod q (registered).
REQ-010 SHALL have port valid_out  output  1  one-cycle result strobe.
REQ-011 SHALL have port zero_err  output  1  operand ≡ 0 mod q, qualified by valid_out.

Function
REQ-012 SHALL compute result = a^(q-2) mod q (Fermat inverse), so result*a ≡ 1 mod q for a mod q ≠ 0.
REQ-013 SHALL drive ready = (state==IDLE) && enable, combinationally.
REQ-014 SHALL accept an operand on an edge where valid_in && ready; valid_in at other times SHALL be ignored, no queuing.
REQ-015 SHALL at acceptance register base = (a >= q) ? a-q : a, acc = 1, bit index = 11, and capture zero flag = (base==0).
REQ-016 SHALL use FSM states IDLE, SQR, MUL: IDLE->SQR on accept; SQR->MUL; MUL->SQR with index-1 if index>0; MUL->IDLE if index==0.
REQ-017 SQR SHALL set acc = acc*acc mod q; MUL SHALL set acc = acc*base mod q if E[index]==1, else hold acc.
REQ-018 SHALL perform exactly one modular product per enabled cycle: 24-bit full product, reduced to [0,q-1] (Barrett or equivalent, fully corrected, no q-offset result).
REQ-019 Fixed latency: 24 enabled compute edges after the accepting edge; on the 24th (MUL, index 0) result and valid_out=1 SHALL be registered, zero_err = captured zero flag.
REQ-020 valid_out and zero_err SHALL be high exactly one cycle, cleared on the next edge regardless of enable.
REQ-021 result SHALL hold its value until the next completion; never updated mid-computation.
REQ-022 enable low SHALL freeze state, acc, base, index; no operation, no acceptance; computation resumes unchanged when enable returns.
REQ-023 Back-to-back: ready SHALL be high in the cycle after valid_out asserts (IDLE reached on completion edge), so next operand accepted one cycle after completion edge.
REQ-024 Operand 0 or 3329 (≡0) SHALL yield result 0 with zero_err=1 after the full 24-cycle latency.

Reset
REQ-025 rst high SHALL asynchronously force state=IDLE, acc=1, base=0, index=11, result=0, valid_out=0, zero_err=0.
REQ-026 rst mid-computation SHALL abort with no valid_out; after rst release the unit SHALL be ready (if enable) and a new operand SHALL compute correctly.

Verification
REQ-027 a=2, enable=1 -> after 24 cycles valid_out=1, result=1665, zero_err=0; ready=1 next cycle.
REQ-028 a=17 then a=3328 back-to-back (second accepted first cycle ready high) -> results 1175 then 3328, each a single valid_out pulse, 24 cycles after its own accept.
REQ-029 a=1 -> 1; a=3329 -> result 0, zero_err=1; a=0 -> result 0, zero_err=1.
REQ-030 a=17, enable deasserted 5 cycles mid-computation -> valid_out at 29 cycles after accept, result=1175; ready=0 throughout.
REQ-031 a=2 accepted, rst pulsed at cycle 10 -> no valid_out, result=0; then a=17 -> 1175 after 24 cycles.
REQ-032 Sweep a=1..3328 against reference check (result*a mod q == 1), plus valid_in held high while busy -> no extra acceptances.
